// File: rtl/deser16_1_pkg.sv
// Shared width constants and assembly-state encoding for the 1:16 deserializer.
package deser16_1_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SEL_W = 4;

    // ASSEMBLE: collecting bits; FULL: a finished word is parked in assembly.
    typedef enum logic {
        ST_ASSEMBLE = 1'b0,
        ST_FULL     = 1'b1
    } asm_state_t;

endpackage

// File: rtl/demux1_16.sv
// 1:16 decoder producing a one-hot bit-write strobe; mirror of the 16:1 select mux.
module demux1_16
    import deser16_1_pkg::*;
(
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_strobe_c
);

    // One strobe bit per position, only while enabled.
    always_comb begin
        o_strobe_c        = '0;
        o_strobe_c[i_sel] = i_en;
    end

endmodule

// File: rtl/deser16_1.sv
// Serial-to-parallel deserializer: LSB-first bit stream into 16-bit words with
// a valid/ready output and one word of skid storage in the assembly register.
module deser16_1
    import deser16_1_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_din,
    input  logic             i_din_valid,
    input  logic             i_din_sof,
    output logic             o_din_ready,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_valid,
    input  logic             i_dout_ready,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_frame_err
);

    asm_state_t       r_state;
    logic [SEL_W-1:0] r_sel;
    logic [WIDTH-1:0] r_asm;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_frame_err;

    logic             w_accept;
    logic [SEL_W-1:0] w_pos;
    logic [WIDTH-1:0] w_strobe;
    logic [WIDTH-1:0] w_asm_next;
    logic             w_complete;
    logic             w_out_free;
    logic             w_handshake;

    // Input side stalls only while a finished word waits in assembly.
    assign o_din_ready = (r_state == ST_ASSEMBLE) && i_rst_n;
    assign w_accept    = i_din_valid && o_din_ready;
    assign w_pos       = i_din_sof ? '0 : r_sel;
    assign w_complete  = w_accept && (w_pos == SEL_W'(WIDTH - 1));
    assign w_handshake = r_dout_valid && i_dout_ready;
    assign w_out_free  = !r_dout_valid || i_dout_ready;

    demux1_16 u_demux (
        .i_sel      (w_pos),
        .i_en       (w_accept),
        .o_strobe_c (w_strobe)
    );

    // Start of frame drops any partial word; otherwise write the strobed bit.
    always_comb begin
        w_asm_next = (r_asm & ~w_strobe) | (w_strobe & {WIDTH{i_din}});
        if (i_din_sof) begin
            w_asm_next = {{(WIDTH - 1){1'b0}}, i_din};
        end
    end

    // Position counter, assembly register, skid state and output register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_ASSEMBLE;
            r_sel        <= '0;
            r_asm        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= w_accept && i_din_sof && (r_sel != '0);
            if (w_accept) begin
                r_asm <= w_asm_next;
                r_sel <= i_din_sof ? SEL_W'(1) : r_sel + SEL_W'(1);
            end
            case (r_state)
                ST_FULL: begin
                    if (w_handshake) begin
                        r_dout  <= r_asm;
                        r_state <= ST_ASSEMBLE;
                    end
                end
                default: begin
                    if (w_complete && w_out_free) begin
                        r_dout       <= w_asm_next;
                        r_dout_valid <= 1'b1;
                    end else if (w_complete) begin
                        r_state <= ST_FULL;
                    end else if (w_handshake) begin
                        r_dout_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_sel        = r_sel;
    assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_deser16_1.sv
// Directed bench for deser16_1 with an expected-word scoreboard.
module tb_deser16_1;
    import deser16_1_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             din_sof = 1'b0;
    logic             dout_ready = 1'b0;
    logic             din_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [SEL_W-1:0] sel;
    logic             frame_err;

    int               n_cmp = 0;
    int               n_err = 0;
    int               fe_cnt = 0;
    int               fe0;
    logic [15:0]      exp_q[$];
    logic [15:0]      mon_exp;

    deser16_1 dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_din        (din),
        .i_din_valid  (din_valid),
        .i_din_sof    (din_sof),
        .o_din_ready  (din_ready),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .i_dout_ready (dout_ready),
        .o_sel        (sel),
        .o_frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold one bit on the input until it is accepted (bounded wait).
    task automatic drive_bit(input logic b, input logic sof);
        int   budget;
        logic acc;
        din       = b;
        din_sof   = sof;
        din_valid = 1'b1;
        budget    = 0;
        acc       = 1'b0;
        while (!acc && budget < 50) begin
            @(negedge clk);
            acc = din_ready;
            tick();
            budget++;
        end
        din_valid = 1'b0;
        din_sof   = 1'b0;
        if (!acc) chk("bit_accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_word(input logic [15:0] w, input logic sof, input int gap_pct,
                             input logic expect_out);
        logic [SEL_W-1:0] s0;
        for (int i = 0; i < 16; i++) begin
            if (gap_pct > 0) begin
                while ($urandom_range(99) < gap_pct) begin
                    s0 = sel;
                    tick();
                    chk("sel_hold_gap", 32'(sel), 32'(s0));
                end
                chk("sel_pos", 32'(sel), 32'(i));
            end
            if (i == 15 && expect_out) exp_q.push_back(w);
            drive_bit(w[i], sof && (i == 0));
        end
    endtask

    // Scoreboard pop on every output handshake; also count frame_err pulses.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (rst_n && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("word", 32'(dout), 32'(mon_exp));
            end
        end
    end

    initial begin
        // Reset
        repeat (2) tick();
        @(negedge clk);
        chk("rst_din_ready", 32'(din_ready), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_din_ready", 32'(din_ready), 32'd1);
        tick();

        // Single word, no backpressure
        dout_ready = 1'b1;
        send_word(16'hA5C3, 1'b0, 0, 1'b1);
        @(negedge clk);
        chk("a5c3_valid", 32'(dout_valid), 32'd1);
        chk("a5c3_dout", 32'(dout), 32'hA5C3);
        chk("a5c3_sel", 32'(sel), 32'd0);
        tick();
        @(negedge clk);
        chk("a5c3_valid_drop", 32'(dout_valid), 32'd0);
        tick();

        // Backpressure: two words, second parks in assembly
        dout_ready = 1'b0;
        send_word(16'h1234, 1'b0, 0, 1'b1);
        send_word(16'hFFFF, 1'b0, 0, 1'b1);
        @(negedge clk);
        chk("bp_din_ready", 32'(din_ready), 32'd0);
        chk("bp_dout", 32'(dout), 32'h1234);
        chk("bp_valid", 32'(dout_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("bp_dout_held", 32'(dout), 32'h1234);
        tick();
        dout_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("bp_valid_drop", 32'(dout_valid), 32'd0);
        chk("bp_din_ready_back", 32'(din_ready), 32'd1);
        chk("bp_dout_last", 32'(dout), 32'hFFFF);
        tick();

        // Resync: partial word truncated by start of frame
        fe0 = fe_cnt;
        for (int i = 0; i < 5; i++) drive_bit(1'($urandom_range(1)), 1'b0);
        chk("resync_sel5", 32'(sel), 32'd5);
        send_word(16'h00F0, 1'b1, 0, 1'b1);
        repeat (3) tick();
        chk("resync_frame_err", 32'(fe_cnt - fe0), 32'd1);
        chk("resync_dout", 32'(dout), 32'h00F0);

        // Valid gaps
        send_word(16'h8001, 1'b0, 30, 1'b1);
        chk("gap_sel_end", 32'(sel), 32'd0);
        repeat (2) tick();
        chk("gap_dout", 32'(dout), 32'h8001);

        // Reset mid-word
        fe0 = fe_cnt;
        for (int i = 0; i < 9; i++) drive_bit(1'b1, 1'b0);
        chk("mid_sel9", 32'(sel), 32'd9);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_din_ready", 32'(din_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_sel", 32'(sel), 32'd0);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        tick();
        send_word(16'h0F0F, 1'b0, 0, 1'b1);
        repeat (3) tick();
        chk("mid_dout", 32'(dout), 32'h0F0F);
        chk("mid_frame_err", 32'(fe_cnt - fe0), 32'd0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/deser16_1.md
# deser16_1

Serial-to-parallel deserializer that steers a 1-bit stream into 16 bit positions of a word, the inverse of the 16:1 select path. A 4-bit position counter acts as the demux select, and completed words are presented on a 16-bit valid/ready output. A skid register absorbs one completed word under backpressure. The block sits at the receive end of the serial link whose transmit side scans a 16:1 mux with a 4-bit select.

## Interface
- WIDTH, 16: output word width; only 16 is supported.
- SEL_W, 4: position counter width, equal to log2(WIDTH).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- din  in  1  serial data bit.
- din_valid  in  1  din is valid this cycle.
- din_sof  in  1  start of frame; qualified by din_valid, and marks the bit as position 0.
- din_ready  out  1  the block can accept a bit this cycle.
- dout  out  WIDTH  assembled word; bit 0 is the first serial bit (LSB-first).
- dout_valid  out  1  dout holds a complete word.
- dout_ready  in  1  downstream accepts dout this cycle.
- sel  out  SEL_W  current write position (demux select), for observability.
- frame_err  out  1  one-cycle pulse when din_sof truncates a partial word.

## Operation
- Accept condition: din_valid && din_ready. Nothing changes on cycles with no accept.
- On accept, din is written into the assembly register at bit asm[sel], and sel increments mod 16.
- If din_sof is set on an accepted bit:
  - The bit goes to position 0 and sel becomes 1.
  - If sel was not 0, the partial word is discarded and frame_err pulses on the next cycle.
- Word completion happens when a bit is accepted with sel==15. The complete word is {din, asm[14:0]}.
  - If the output is free (!dout_valid, or dout_valid && dout_ready in the same cycle), the word loads into dout and dout_valid is 1 next cycle.
  - Otherwise the word is held in assembly and asm_full sets.
- din_ready = !asm_full && rst_n.
- While asm_full is set, an output handshake (dout_valid && dout_ready) moves the assembly word into dout. dout_valid stays 1, asm_full clears, and din_ready returns next cycle.
- A handshake with no replacement word clears dout_valid next cycle. dout holds its last value.
- dout and dout_valid are stable while dout_valid && !dout_ready.
- Sequence of states: ASSEMBLE (sel 0..15, asm_full=0) → FULL (asm_full=1) → ASSEMBLE. The output register is an independent empty/valid flag.
- Reset (rst_n=0 at an edge), including mid-word:
  - sel=0, asm_full=0, dout=16'h0000, dout_valid=0, frame_err=0.
  - Any partial word is discarded.
  - din_ready=0 while rst_n is low.

## Timing
- Latency: the 16th bit is accepted at edge t, and dout_valid=1 is visible after t. This is the minimum, with 1 bit/cycle and 16 cycles per word.
- Under continuous dout_ready=1 with din_valid=1, throughput is one word per 16 cycles with no bubbles.
- frame_err is registered: high for exactly one cycle after the offending accept.
- sel is a registered output and shows the position the next accepted bit will occupy.
- Simultaneous word completion and output handshake: the new word replaces the old one and dout_valid stays high.

## Structure
- Width constants (WIDTH=16, SEL_W=4) go in a shared include. No typedefs are needed.
- Sub-module demux1_16: combinational 1:16 decoder from sel and an enable to a 16-bit one-hot bit-write strobe. It is the mirror of the 16:1 mux and is reused by the assembly register.
- The top level holds the counter, assembly register, asm_full, the output register, and the handshake logic.

## Test plan
- Reset: rst_n=0 for 2 cycles, then released. Required: dout=0, dout_valid=0, sel=0, frame_err=0. din_ready is 0 during reset and 1 on the first cycle after release.
- Single word, no backpressure: send 16'hA5C3 LSB-first with dout_ready=1. Required: dout=16'hA5C3 and dout_valid high for exactly one cycle, starting the cycle after the 16th bit; sel returns to 0.
- Backpressure:
  - With dout_ready=0, send 16'h1234 then 16'hFFFF. Required: after the 32nd bit, din_ready=0 and dout=16'h1234 is held.
  - Then dout_ready=1 for 2 cycles. Required: 16'h1234 and then 16'hFFFF are each accepted once, with dout_valid falling after the second word and din_ready=1 again.
- Resync: send 5 bits, then din_sof with word 16'h00F0. Required: frame_err pulses exactly once and dout=16'h00F0 follows with no output of the partial word.
- Valid gaps: send 16'h8001 with din_valid randomly low (30%). Required: the result is identical, and sel advances only on accepts.
- Reset mid-word: after 9 bits, pulse rst_n low for 1 cycle, then send 16'h0F0F. Required: no word is emitted from the first 9 bits, the output is exactly 16'h0F0F, and frame_err stays 0.
